// File: rtl/iir_delay_line_ctrl_pkg.sv
// Shared definitions for the IIR sample delay line: controller state encoding
// and the address-width helper used by both the controller and the sample RAM.
package iir_delay_line_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // ceil(log2(n)), never less than 1 so a 2-entry RAM still gets a real address bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/iir_delay_line_ctrl.sv
// Circular delay-line sequencer for the IIR sample RAM: zero-fills after reset,
// writes each accepted sample, then streams taps x[n]..x[n-DEPTH+1] downstream.
module iir_delay_line_ctrl
  import iir_delay_line_ctrl_pkg::*;
#(
  parameter  int DEPTH     = 8,
  parameter  int dataWidth = 6,
  localparam int addWidth  = clog2_min1(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [dataWidth-1:0] in_data,
  output logic                 ram_we,
  output logic [addWidth-1:0]  ram_addr,
  output logic [dataWidth-1:0] ram_din,
  input  logic [dataWidth-1:0] ram_dout,
  output logic                 tap_valid,
  input  logic                 tap_ready,
  output logic [dataWidth-1:0] tap_data,
  output logic [addWidth-1:0]  tap_idx,
  output logic                 tap_last
);

  localparam logic [addWidth-1:0] LAST_IDX = addWidth'(DEPTH - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [addWidth-1:0]    r_init_cnt;
  logic [addWidth-1:0]    r_wptr;
  logic [addWidth-1:0]    r_raddr;
  logic [addWidth-1:0]    r_k;
  logic [dataWidth-1:0]   r_sample;
  logic                   r_tap_valid;
  logic [dataWidth-1:0]   r_tap_data;
  logic [addWidth-1:0]    r_tap_idx;
  logic                   r_tap_last;
  logic                   w_issue;

  // A new tap may be loaded whenever the output register is empty or being consumed.
  assign w_issue = !r_tap_valid || tap_ready;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_INIT;
    else      r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next   = r_state;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    in_ready = 1'b0;
    case (r_state)
      ST_INIT: begin
        ram_we   = 1'b1;
        ram_addr = r_init_cnt;
        if (r_init_cnt == LAST_IDX) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        in_ready = 1'b1;
        if (clr)           w_next = ST_INIT;
        else if (in_valid) w_next = ST_WRITE;
      end
      ST_WRITE: begin
        ram_we   = 1'b1;
        ram_addr = r_wptr;
        ram_din  = r_sample;
        w_next   = ST_READ;
      end
      ST_READ: begin
        ram_addr = r_raddr;
        if (w_issue && (r_k == LAST_IDX)) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_tap_valid && tap_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_init_cnt  <= '0;
      r_wptr      <= '0;
      r_raddr     <= '0;
      r_k         <= '0;
      r_sample    <= '0;
      r_tap_valid <= 1'b0;
      r_tap_data  <= '0;
      r_tap_idx   <= '0;
      r_tap_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == LAST_IDX) begin
            r_init_cnt <= '0;
            r_wptr     <= '0;
          end else begin
            r_init_cnt <= r_init_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clr) begin
            r_init_cnt <= '0;
            r_wptr     <= '0;
          end else if (in_valid) begin
            r_sample <= in_data;
          end
        end
        ST_WRITE: begin
          r_raddr <= r_wptr;
          r_k     <= '0;
        end
        ST_READ: begin
          if (w_issue) begin
            r_tap_data  <= ram_dout;
            r_tap_idx   <= r_k;
            r_tap_last  <= (r_k == LAST_IDX);
            r_tap_valid <= 1'b1;
            r_raddr     <= (r_raddr == '0) ? LAST_IDX : r_raddr - 1'b1;
            r_k         <= r_k + 1'b1;
            // Advance the write pointer once the oldest tap has been issued.
            if (r_k == LAST_IDX)
              r_wptr <= (r_wptr == LAST_IDX) ? '0 : r_wptr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_tap_valid && tap_ready) r_tap_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign tap_valid = r_tap_valid;
  assign tap_data  = r_tap_data;
  assign tap_idx   = r_tap_idx;
  assign tap_last  = r_tap_last;

endmodule

// File: tb/tb_iir_delay_line_ctrl.sv
// Directed bench for iir_delay_line_ctrl: a DEPTH=4 and a DEPTH=5 instance,
// each beside a behavioural async-read RAM pre-filled with non-zero junk.
module tb_iir_delay_line_ctrl;

  logic       CLK;
  logic       RST;

  logic       clr0, iv0, tr0, ir0, we0, tv0, tl0;
  logic [5:0] id0, din0, dout0, td0;
  logic [1:0] addr0, idx0;

  logic       clr1, iv1, tr1, ir1, we1, tv1, tl1;
  logic [5:0] id1, din1, dout1, td1;
  logic [2:0] addr1, idx1;

  logic [5:0] mem0 [4];
  logic [5:0] mem1 [5];

  int checks    = 0;
  int failures  = 0;
  int sel       = 0;
  int bad_addr  = 0;
  int wp0       = 0;
  int wp1       = 0;
  logic [5:0] hist0 [$];
  logic [5:0] hist1 [$];
  logic [5:0] got_d [8];
  int         got_i [8];
  logic       got_l [8];

  logic       m_in_ready, m_we, m_tap_valid, m_tap_last;
  logic [2:0] m_addr, m_idx;
  logic [5:0] m_din, m_tap_data;

  iir_delay_line_ctrl #(.DEPTH(4), .dataWidth(6)) u_dut4 (
    .CLK(CLK), .RST(RST), .clr(clr0), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .ram_we(we0), .ram_addr(addr0), .ram_din(din0), .ram_dout(dout0),
    .tap_valid(tv0), .tap_ready(tr0), .tap_data(td0), .tap_idx(idx0), .tap_last(tl0)
  );

  iir_delay_line_ctrl #(.DEPTH(5), .dataWidth(6)) u_dut5 (
    .CLK(CLK), .RST(RST), .clr(clr1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .ram_we(we1), .ram_addr(addr1), .ram_din(din1), .ram_dout(dout1),
    .tap_valid(tv1), .tap_ready(tr1), .tap_data(td1), .tap_idx(idx1), .tap_last(tl1)
  );

  initial begin
    for (int i = 0; i < 4; i++) mem0[i] = 6'h2A;
    for (int i = 0; i < 5; i++) mem1[i] = 6'h2A;
  end

  always @(posedge CLK) begin
    if (we0) mem0[addr0] <= din0;
    if (we1 && addr1 < 3'd5) mem1[addr1] <= din1;
  end

  assign dout0 = mem0[addr0];
  assign dout1 = (addr1 < 3'd5) ? mem1[addr1] : 6'h3F;

  always @(negedge CLK) if (RST && addr1 > 3'd4) bad_addr++;

  always_comb begin
    if (sel == 0) begin
      m_in_ready = ir0; m_we = we0; m_tap_valid = tv0; m_tap_last = tl0;
      m_addr = {1'b0, addr0}; m_idx = {1'b0, idx0}; m_din = din0; m_tap_data = td0;
    end else begin
      m_in_ready = ir1; m_we = we1; m_tap_valid = tv1; m_tap_last = tl1;
      m_addr = addr1; m_idx = idx1; m_din = din1; m_tap_data = td1;
    end
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [5:0] d);
    if (sel == 0) begin iv0 = v; id0 = d; end
    else          begin iv1 = v; id1 = d; end
  endtask

  task automatic set_ready(input logic r);
    if (sel == 0) tr0 = r;
    else          tr1 = r;
  endtask

  function automatic logic [5:0] exp_tap(input int k);
    if (sel == 0) return (k < hist0.size()) ? hist0[k] : 6'd0;
    else          return (k < hist1.size()) ? hist1[k] : 6'd0;
  endfunction

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!m_in_ready && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("in_ready_wait", m_in_ready, 1'b1);
  endtask

  // Collect 'depth' accepted taps; stall tap_ready for 3 cycles at tap stall_k (-1: never).
  task automatic collect(input int depth, input int stall_k);
    int n, cyc, stall;
    logic [5:0] sd;
    logic [2:0] si;
    n = 0; cyc = 0; stall = 3; sd = '0; si = '0;
    while (n < depth && cyc < 200) begin
      if (m_tap_valid && stall_k >= 0 && int'(m_idx) == stall_k && stall > 0) begin
        if (stall == 3) begin
          sd = m_tap_data;
          si = m_idx;
        end else begin
          check("stall_data", m_tap_data, sd);
          check("stall_idx", m_idx, si);
          check("stall_valid", m_tap_valid, 1'b1);
        end
        check("stall_in_ready", m_in_ready, 1'b0);
        set_ready(1'b0);
        set_in(1'b1, 6'h3F);
        stall--;
      end else begin
        set_ready(1'b1);
        set_in(1'b0, 6'h00);
        if (m_tap_valid) begin
          got_d[n] = m_tap_data;
          got_i[n] = int'(m_idx);
          got_l[n] = m_tap_last;
          n++;
        end
      end
      @(negedge CLK);
      cyc++;
    end
    check("tap_count", n, depth);
  endtask

  task automatic push(input logic [5:0] x, input int depth, input int stall_k);
    int wp;
    wait_ready(50);
    set_in(1'b1, x);
    @(negedge CLK);
    set_in(1'b0, 6'h00);
    wp = (sel == 0) ? wp0 : wp1;
    check("write_we", m_we, 1'b1);
    check("write_addr", m_addr, wp);
    check("write_din", m_din, x);
    check("write_in_ready", m_in_ready, 1'b0);
    if (sel == 0) begin hist0.push_front(x); wp0 = (wp0 + 1) % depth; end
    else          begin hist1.push_front(x); wp1 = (wp1 + 1) % depth; end
    @(negedge CLK);
    check("first_read_no_tap", m_tap_valid, 1'b0);
    collect(depth, stall_k);
    for (int k = 0; k < depth; k++) begin
      check($sformatf("tap%0d_data", k), got_d[k], exp_tap(k));
      check($sformatf("tap%0d_idx", k), got_i[k], k);
      check($sformatf("tap%0d_last", k), got_l[k], (k == depth - 1));
    end
    check("in_ready_after_drain", m_in_ready, 1'b1);
  endtask

  task automatic clear_models();
    hist0.delete();
    hist1.delete();
    wp0 = 0;
    wp1 = 0;
  endtask

  initial begin
    RST = 1'b0;
    clr0 = 1'b0; iv0 = 1'b0; id0 = '0; tr0 = 1'b1;
    clr1 = 1'b0; iv1 = 1'b0; id1 = '0; tr1 = 1'b1;
    repeat (2) @(negedge CLK);

    check("rst_tap_valid", tv0, 1'b0);
    check("rst_tap_data", td0, 6'd0);
    check("rst_tap_idx", idx0, 2'd0);
    check("rst_tap_last", tl0, 1'b0);
    check("rst_ram_we", we0, 1'b1);
    check("rst_ram_addr", addr0, 2'd0);
    check("rst_ram_din", din0, 6'd0);
    check("rst_in_ready", ir0, 1'b0);

    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("init%0d_we", i), we0, 1'b1);
      check($sformatf("init%0d_addr", i), addr0, i);
      check($sformatf("init%0d_din", i), din0, 6'd0);
      check($sformatf("init%0d_in_ready", i), ir0, 1'b0);
      @(negedge CLK);
    end
    check("idle_in_ready", ir0, 1'b1);
    check("idle_ram_we", we0, 1'b0);

    sel = 0;
    push(6'd5, 4, -1);
    push(6'd6, 4, -1);
    push(6'd7, 4, -1);
    push(6'd8, 4, -1);
    push(6'd9, 4, -1);
    check("wptr_wrapped", wp0, 1);
    push(6'd10, 4, 1);

    wait_ready(50);
    set_in(1'b1, 6'd11);
    @(negedge CLK);
    set_in(1'b0, 6'd0);
    @(negedge CLK);
    @(negedge CLK);
    check("mid_tap_valid_pre", tv0, 1'b1);
    RST = 1'b0;
    #1;
    check("mid_rst_tap_valid", tv0, 1'b0);
    check("mid_rst_ram_we", we0, 1'b1);
    check("mid_rst_ram_addr", addr0, 2'd0);
    check("mid_rst_in_ready", ir0, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    clear_models();
    push(6'd3, 4, -1);

    push(6'd4, 4, -1);
    wait_ready(50);
    clr0 = 1'b1;
    set_in(1'b1, 6'd12);
    @(negedge CLK);
    clr0 = 1'b0;
    set_in(1'b0, 6'd0);
    check("clr_ram_we", we0, 1'b1);
    check("clr_ram_addr", addr0, 2'd0);
    check("clr_ram_din", din0, 6'd0);
    check("clr_in_ready", ir0, 1'b0);
    hist0.delete();
    wp0 = 0;
    push(6'd3, 4, -1);

    sel = 1;
    for (int v = 1; v <= 7; v++) push(6'(v), 5, -1);
    check("d5_wptr_model", wp1, 2);
    check("d5_addr_in_range", bad_addr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
